// File: rtl/core_sequencer_pkg.sv
// Shared types and opcode-class bit positions for the RV32I control sequencer.
// trap_cause is only meaningful while trap is set; a cleared cause reads as 0.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TC_ILLEGAL     = 2'd0,
    TC_ECALL       = 2'd1,
    TC_MISALIGNED  = 2'd2,
    TC_BUS_TIMEOUT = 2'd3
  } trap_cause_t;

  localparam trap_cause_t TC_NONE = TC_ILLEGAL;

  localparam int OP_CLASS_W         = 10;
  localparam int OP_REGISTER_ARITH  = 0;
  localparam int OP_IMMEDIATE_ARITH = 1;
  localparam int OP_LOAD            = 2;
  localparam int OP_STORE           = 3;
  localparam int OP_BRANCH          = 4;
  localparam int OP_IMMEDIATE_JUMP  = 5;
  localparam int OP_REGISTER_JUMP   = 6;
  localparam int OP_LOAD_UPPER      = 7;
  localparam int OP_LOAD_UPPER_PC   = 8;
  localparam int OP_ENVIRONMENT     = 9;

  // True when the instruction leaves the sequential path for the ALU target.
  function automatic logic takes_redirect(input logic [OP_CLASS_W-1:0] cls,
                                          input logic branch_taken);
    return cls[OP_IMMEDIATE_JUMP] | cls[OP_REGISTER_JUMP] |
           (cls[OP_BRANCH] & branch_taken);
  endfunction

endpackage

// File: rtl/core_sequencer_handshake_timer.sv
// Wait-cycle watchdog for a held bus request. start is high for every cycle the
// request is held; expired fires on the last allowed cycle if ready is still low.
module handshake_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Clearing on ready lets a store completion re-arm the timer for the next fetch.
  always_ff @(posedge clk) begin
    if (rst || !start || ready) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = start && !ready && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the RV32I core: fetch, decode wait, execute,
// memory and writeback, with PC update, retire counting and sticky traps.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction_data,
  input  logic [OP_CLASS_W-1:0] op_class,
  input  logic                  opcode_valid,
  input  logic [4:0]            write_register,
  input  logic                  write_register_valid,
  input  logic                  branch_taken,
  input  logic [31:0]           target_pc,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  output logic                  rf_we,
  output logic [31:0]           pc,
  output logic [2:0]            state,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [31:0]           instret
);

  // Bus handshake: req rises on entering FETCH/MEMORY and is held until the
  // cycle ready is high; that cycle completes the transfer (rdata sampled then).

  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;
  logic [31:0] pc_q, next_pc_q, ir_q, instret_q, exec_next_pc;
  logic        trap_q, redirect, illegal, is_mem, retire;
  logic        timer_start, timer_ready, timer_expired;

  assign redirect     = takes_redirect(op_class, branch_taken);
  assign exec_next_pc = redirect ? target_pc : pc_q + 32'd4;
  assign illegal      = !opcode_valid || (op_class == '0);
  assign is_mem       = op_class[OP_LOAD] | op_class[OP_STORE];
  assign retire       = (state_q == S_WRITEBACK) ||
                        (state_q == S_MEMORY && dmem_ready && !op_class[OP_LOAD]);

  assign timer_start = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign timer_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  handshake_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .ready   (timer_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= TC_NONE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      trap_q  <= trap_q | (state_d == S_TRAP);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timer_expired) begin
          state_d = S_TRAP;
          cause_d = TC_BUS_TIMEOUT;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else if (op_class[OP_ENVIRONMENT]) begin
          state_d = S_TRAP;
          cause_d = TC_ECALL;
        end else if (redirect && target_pc[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = TC_MISALIGNED;
        end else begin
          state_d = is_mem ? S_MEMORY : S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ready) begin
          state_d = op_class[OP_LOAD] ? S_WRITEBACK : S_FETCH;
        end else if (timer_expired) begin
          state_d = S_TRAP;
          cause_d = TC_BUS_TIMEOUT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Strobes are held low while reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH:     imem_req = 1'b1;
        S_MEMORY: begin
          dmem_req = 1'b1;
          dmem_we  = op_class[OP_STORE];
        end
        S_WRITEBACK: rf_we = write_register_valid && (write_register != 5'd0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
      if (state_q == S_EXECUTE) next_pc_q <= exec_next_pc;
      if (retire) begin
        pc_q      <= next_pc_q;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign instruction_data = ir_q;
  assign instret          = instret_q;
  assign state            = state_q;
  assign trap             = trap_q;
  assign trap_cause       = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a registered RV32I opcode decoder, an instruction-level
// model that scripts the expected per-cycle outputs, and a per-cycle compare.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam int TMO = 4;
  localparam int W   = 138;
  localparam logic [1:0] C_ILLEGAL = 2'd0, C_ECALL = 2'd1, C_MISALIGNED = 2'd2, C_TIMEOUT = 2'd3;

  logic        clk, rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, rf_we, trap;
  logic [31:0] imem_addr, imem_rdata, instruction_data, target_pc, pc, instret;
  logic [9:0]  op_class;
  logic        opcode_valid, write_register_valid, branch_taken;
  logic [4:0]  write_register;
  logic [2:0]  state;
  logic [1:0]  trap_cause;

  core_sequencer #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction_data(instruction_data),
    .op_class(op_class), .opcode_valid(opcode_valid), .write_register(write_register),
    .write_register_valid(write_register_valid), .branch_taken(branch_taken),
    .target_pc(target_pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- decoder model ----------------
  // {valid, environment, load_upper_pc, load_upper, register_jump, immediate_jump,
  //  branch, store, load, immediate_arith, register_arith}
  function automatic logic [10:0] decode(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 11'b1_00000_00001;
      7'b0010011: return 11'b1_00000_00010;
      7'b0000011: return 11'b1_00000_00100;
      7'b0100011: return 11'b1_00000_01000;
      7'b1100011: return 11'b1_00000_10000;
      7'b1101111: return 11'b1_00001_00000;
      7'b1100111: return 11'b1_00010_00000;
      7'b0110111: return 11'b1_00100_00000;
      7'b0010111: return 11'b1_01000_00000;
      7'b1110011: return 11'b1_10000_00000;
      default:    return 11'b0;
    endcase
  endfunction

  function automatic logic rd_meaningful(input logic [10:0] d);
    return d[10] & !(d[3] | d[4] | d[9]);
  endfunction

  always @(posedge clk) begin
    {opcode_valid, op_class} <= decode(instruction_data);
    write_register           <= instruction_data[11:7];
    write_register_valid     <= rd_meaningful(decode(instruction_data));
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] m_pc, m_instret, m_ir;
  logic        m_trap;
  logic [1:0]  m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {state, imem_req, dmem_req, dmem_we, rf_we, trap, trap_cause,
           pc, instret, instruction_data, imem_addr};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL trace @%0t {st,ireq,dreq,dwe,rfwe,trap,cause,pc,instret,ir,iaddr}: got %h expected %h",
                 $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Records the expected outputs for the cycle just set up, then advances one cycle.
  task automatic cycle(input logic [2:0] st, input logic ireq, input logic dreq,
                       input logic dwe, input logic rfwe);
    exp_q.push_back({st, ireq, dreq, dwe, rfwe, m_trap, m_cause,
                     m_pc, m_instret, m_ir, m_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pc = 32'h0; m_instret = 32'h0; m_ir = 32'h0; m_trap = 1'b0; m_cause = 2'd0;
  endtask

  task automatic take_trap(input logic [1:0] c);
    m_trap  = 1'b1;
    m_cause = c;
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      cycle(S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // One instruction end to end; fwait/mwait = cycles before ready, rst_mem = memory
  // cycle index at which reset is asserted (-1 for none).
  task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                           input logic taken, input logic [31:0] target, input int rst_mem);
    logic [10:0] d;
    logic        redirect, ld, st, rfwe;
    logic [31:0] npc;
    d        = decode(instr);
    ld       = d[2];
    st       = d[3];
    redirect = d[5] | d[6] | (d[4] & taken);
    npc      = redirect ? target : m_pc + 32'd4;
    rfwe     = rd_meaningful(d) && (instr[11:7] != 5'd0);
    branch_taken = taken;
    target_pc    = target;
    dmem_ready   = 1'b0;
    for (int i = 0; i <= fwait; i++) begin
      if (i == TMO) begin take_trap(C_TIMEOUT); return; end
      imem_ready = (i == fwait);
      imem_rdata = (i == fwait) ? instr : $urandom;
      cycle(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    m_ir       = instr;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    cycle(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(S_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!d[10]) begin take_trap(C_ILLEGAL); return; end
    if (d[9]) begin take_trap(C_ECALL); return; end
    if (redirect && target[1:0] != 2'b00) begin take_trap(C_MISALIGNED); return; end
    if (ld || st) begin
      for (int i = 0; i <= mwait; i++) begin
        if (i == rst_mem) begin do_reset(); return; end
        if (i == TMO) begin take_trap(C_TIMEOUT); return; end
        dmem_ready = (i == mwait);
        cycle(S_MEMORY, 1'b0, 1'b1, st, 1'b0);
      end
      dmem_ready = 1'b0;
      if (st) begin
        m_pc = npc;
        m_instret = m_instret + 32'd1;
        return;
      end
    end
    cycle(S_WRITEBACK, 1'b0, 1'b0, 1'b0, rfwe);
    m_pc = npc;
    m_instret = m_instret + 32'd1;
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                           7'b0010111, 7'b1110011, 7'b1111111, 7'b0000000};

  function automatic int pick_wait();
    int p;
    p = $urandom_range(0, 19);
    if (p < 12) return 0;
    if (p < 19) return $urandom_range(1, TMO - 1);
    return $urandom_range(TMO, TMO + 2);
  endfunction

  initial begin
    logic [31:0] r, t;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; dmem_ready = 1'b0;
    branch_taken = 1'b0; target_pc = 32'h0;
    m_pc = 32'h0; m_instret = 32'h0; m_ir = 32'h0; m_trap = 1'b0; m_cause = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_state", state, 32'(S_FETCH));
    check("reset_pc", pc, 32'h0);
    check("reset_ir", instruction_data, 32'h0);
    check("reset_trap", trap, 32'h0);
    check("reset_instret", instret, 32'h0);
    check("reset_strobes", {dmem_req, dmem_we, rf_we}, 32'h0);

    run_instr(32'h0170_0793, 2, 0, 1'b0, 32'h0, -1);        // addi x15,x0,23
    check("addi_pc", pc, 32'h4);
    check("addi_instret", instret, 32'h1);
    run_instr(32'h0000_2083, 0, 2, 1'b0, 32'h0, -1);        // lw x1,0(x0)
    check("lw_pc", pc, 32'h8);
    check("lw_instret", instret, 32'h2);
    run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40, -1);       // beq taken
    check("beq_pc", pc, 32'h40);
    check("beq_imem_addr", imem_addr, 32'h40);
    run_instr(32'h0010_2023, 3, 1, 1'b0, 32'h0, -1);        // sw, ready on last allowed fetch cycle
    check("sw_pc", pc, 32'h44);
    check("sw_instret", instret, 32'h4);
    run_instr(32'h0170_0793, TMO, 0, 1'b0, 32'h0, -1);      // fetch timeout
    check("timeout_cause", {trap, trap_cause}, 32'h7);
    do_reset();
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0, -1);        // illegal
    check("illegal_cause", {trap, trap_cause}, 32'h4);
    check("illegal_no_req", imem_req, 32'h0);
    do_reset();
    run_instr(32'h0170_0793, 0, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0000_00EF, 0, 0, 1'b0, 32'h42, -1);       // jal to misaligned target
    check("misaligned_cause", {trap, trap_cause}, 32'h6);
    check("misaligned_pc", pc, 32'h4);
    do_reset();
    run_instr(32'h0170_0793, 0, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0000_2083, 0, 3, 1'b0, 32'h0, 1);         // reset during MEMORY
    check("rst_mem_dmem_req", dmem_req, 32'h0);
    check("rst_mem_state", state, 32'(S_FETCH));
    check("rst_mem_pc", pc, 32'h0);
    check("rst_mem_instret", instret, 32'h0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      t = $urandom;
      t[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_instr({r[31:7], ops[$urandom_range(0, 11)]}, pick_wait(), pick_wait(),
                1'($urandom_range(0, 1)), t, -1);
      if (m_trap) do_reset();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
